nv_nvdla_sdp_rdma_split: RTL and testbench
==========================================

# nv_nvdla_sdp_rdma_split

Width splitter on the SDP read path: accepts one OW-wide word from the DMA read return and emits it as a sequence of IW-wide beats toward the SDP datapath. It is the inverse of the WDMA packer. In 16-bit mode it emits RATIO full beats. In 8-bit mode it emits 2*RATIO beats, each carrying IHW payload bits in the low half. The block is a single-word holding register, a beat counter and a valid/ready handshake on both sides.

## Interface
Parameters:
- IW, 256, output beat width; must be even.
- IHW, IW/2, half-beat payload width used in 8-bit mode.
- OW, 256, input word width; OW/IW must be in {1,2,4,8}.
- RATIO, OW/IW, full beats per word.

Ports:
- nvdla_core_clk  input  1  core clock.
- nvdla_core_rst  input  1  reset; one clock, synchronous, active-high.
- cfg_dp_8  input  1  1 = 8-bit precision (half-beat split); 0 = 16-bit (full-beat split).
- inp_pvld  input  1  input word valid.
- inp_prdy  output  1  input word ready.
- inp_data  input  OW  input word.
- out_pvld  output  1  output beat valid.
- out_prdy  input  1  output beat ready.
- out_data  output  IW  output beat.
- out_last  output  1  present only with NVDLA_SDP_SPLIT_LAST_EN; marks the final beat of a word.

## Operation
- State:
  - hold_vld (1b).
  - hold_data (OW).
  - hold_dp8 (1b, cfg_dp_8 captured at word accept).
  - cnt (4b beat index).
- Two states:
  - EMPTY (hold_vld=0).
  - FULL (hold_vld=1).
- Beat count:
  - nbeat = 2*RATIO if hold_dp8, else RATIO.
  - is_last = (cnt == nbeat-1).
- inp_prdy = !hold_vld | (out_prdy & is_last).
- inp_acc = inp_pvld & inp_prdy. On inp_acc:
  - hold_data <= inp_data.
  - hold_dp8 <= cfg_dp_8.
  - cnt <= 0.
  - hold_vld <= 1.
- out_pvld = hold_vld.
- out_acc = out_pvld & out_prdy. On out_acc:
  - If !is_last: cnt <= cnt+1.
  - If is_last and no simultaneous inp_acc: hold_vld <= 0, cnt <= 0.
  - If is_last with simultaneous inp_acc: the load wins; zero-bubble back-to-back words.
- Beat data, k = cnt:
  - 16-bit: out_data = hold_data[k*IW +: IW].
  - 8-bit: out_data = {IHW'b0, hold_data[k*IHW +: IHW]}; upper half is forced to zero.
- cfg_dp_8 changes while FULL have no effect until the next word accept.
- RATIO=8 with 8-bit mode gives 16 beats, cnt 0..15. The 4-bit counter never wraps past is_last.
- While out_pvld=1 and out_prdy=0: out_data and out_last stay stable, and no state changes.

## Timing
- Reset values (nvdla_core_rst high at a clock edge):
  - hold_vld=0, cnt=0, hold_dp8=0.
  - Therefore out_pvld=0, inp_prdy=1, out_last=0.
  - hold_data is not reset.
- Reset mid-word: the remaining beats are discarded. The first cycle after reset release shows inp_prdy=1.
- Latency: a word accepted at edge N produces its first beat valid in the cycle after N.
- Throughput: one beat per clock. A word occupies exactly nbeat output cycles with no bubbles between words when inp_pvld is held.
- inp_prdy depends combinationally on out_prdy. out_pvld and out_data are registered, with no combinational path from the input side.

## Configuration
- NVDLA_SDP_SPLIT_LAST_EN:
  - Defined: port out_last exists, out_last = hold_vld & is_last.
  - Undefined: port and logic are absent. Data and handshake behaviour are identical in both builds.

## Structure
- Shared package nv_nvdla_sdp_pkg:
  - Legal-ratio check constant (RATIO in {1,2,4,8}).
  - Counter width constant (4).
  - Beat-count function nbeat(ratio, dp8), reused by the WDMA packer for its last-beat compare.
- Sub-module: nv_nvdla_sdp_split_mux, a purely combinational beat selector (hold_data, cnt, hold_dp8 -> out_data). Everything else lives in the top.

## Test plan
All scenarios use IW=256, OW=512, RATIO=2 unless stated.
- 16-bit, one word: 512'h{B..B,A..A} (low 256 bits = A), out_prdy=1 -> two beats A then B on consecutive cycles; out_last on beat 2; inp_prdy low during beat 1.
- 8-bit, one word of bytes 0x00..0x3F:
  - Expected: four beats; beat k low 128 bits = bytes 16k..16k+15, upper 128 bits = 0.
  - Word sent while cfg_dp_8 toggles mid-word: still four beats.
- Back-to-back: 3 words with inp_pvld held and out_prdy=1 -> 6 beats over 6 consecutive cycles, no idle cycle, inp_prdy high only on each last beat.
- Backpressure: out_prdy=0 for 5 cycles during beat 1 -> out_data and out_pvld stable, cnt unchanged; no input accepted; beat order preserved on release.
- Reset mid-word: assert nvdla_core_rst after beat 1 of 4 (8-bit) -> next cycle out_pvld=0 and inp_prdy=1; a new word then starts at beat 0.
- RATIO=8 (OW=2048), 8-bit mode: 16 beats per word; cnt reaches 15 and returns to 0; the next word starts cleanly.

Source files
------------

// File: rtl/nv_nvdla_sdp_pkg.sv
// Shared SDP DMA definitions: legal width ratios, beat counter width and the
// per-word beat count used by both the RDMA splitter and the WDMA packer.
package nv_nvdla_sdp_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } split_state_t;

  function automatic bit ratio_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4) || (ratio == 8);
  endfunction

  // 8-bit precision halves the payload per beat, so a word needs twice the beats
  function automatic logic [CNT_W:0] nbeat(input int ratio, input logic dp8);
    return dp8 ? (CNT_W+1)'(2 * ratio) : (CNT_W+1)'(ratio);
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_split_mux.sv
// Combinational beat selector: picks beat cnt out of the held word, either a
// full IW slice or a zero-extended IHW slice in 8-bit mode.
module nv_nvdla_sdp_split_mux
  import nv_nvdla_sdp_pkg::*;
#(
  parameter int IW    = 256,
  parameter int IHW   = IW / 2,
  parameter int OW    = 256,
  parameter int RATIO = OW / IW
) (
  input  logic [OW-1:0]    hold_data,
  input  logic [CNT_W-1:0] cnt,
  input  logic             dp8,
  output logic [IW-1:0]    out_data
);

  logic [IW-1:0]  full_beat;
  logic [IHW-1:0] half_beat;

  always_comb begin
    full_beat = '0;
    half_beat = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt == CNT_W'(k)) full_beat = hold_data[k*IW +: IW];
    end
    for (int k = 0; k < 2 * RATIO; k++) begin
      if (cnt == CNT_W'(k)) half_beat = hold_data[k*IHW +: IHW];
    end
    out_data = dp8 ? {{(IW-IHW){1'b0}}, half_beat} : full_beat;
  end

endmodule

// File: rtl/nv_nvdla_sdp_rdma_split.sv
// SDP RDMA width splitter: one OW word in, RATIO (or 2*RATIO in 8-bit mode)
// IW beats out. Define NVDLA_SDP_SPLIT_LAST_EN to add the out_last port.
module nv_nvdla_sdp_rdma_split
  import nv_nvdla_sdp_pkg::*;
#(
  parameter int IW    = 256,
  parameter int IHW   = IW / 2,
  parameter int OW    = 256,
  parameter int RATIO = OW / IW
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          cfg_dp_8,
  input  logic          inp_pvld,
  output logic          inp_prdy,
  input  logic [OW-1:0] inp_data,
  output logic          out_pvld,
  input  logic          out_prdy,
  output logic [IW-1:0] out_data
`ifdef NVDLA_SDP_SPLIT_LAST_EN
  ,
  output logic          out_last
`endif
);

  localparam bit CFG_OK = ratio_legal(RATIO) && (IW % 2 == 0) && (OW == RATIO * IW);

  if (!CFG_OK) begin : g_bad_cfg
    $error("nv_nvdla_sdp_rdma_split: illegal IW/OW/RATIO combination");
  end

  split_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hold_dp8;
  logic [OW-1:0]    hold_data;
  logic             hold_vld;
  logic             is_last;
  logic             inp_acc;
  logic             out_acc;

  assign hold_vld = (state == FULL);
  assign is_last  = ({1'b0, cnt} == (nbeat(RATIO, hold_dp8) - (CNT_W+1)'(1)));
  assign inp_prdy = !hold_vld | (out_prdy & is_last);
  assign inp_acc  = inp_pvld & inp_prdy;
  assign out_pvld = hold_vld;
  assign out_acc  = out_pvld & out_prdy;

  // A load on the last beat takes priority so words stream without bubbles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (inp_acc) begin
      state_nxt = FULL;
      cnt_nxt   = '0;
    end else if (out_acc) begin
      if (is_last) begin
        state_nxt = EMPTY;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state    <= EMPTY;
      cnt      <= '0;
      hold_dp8 <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (inp_acc) hold_dp8 <= cfg_dp_8;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (inp_acc) hold_data <= inp_data;
  end

  nv_nvdla_sdp_split_mux #(
    .IW    (IW),
    .IHW   (IHW),
    .OW    (OW),
    .RATIO (RATIO)
  ) u_mux (
    .hold_data (hold_data),
    .cnt       (cnt),
    .dp8       (hold_dp8),
    .out_data  (out_data)
  );

`ifdef NVDLA_SDP_SPLIT_LAST_EN
  assign out_last = hold_vld & is_last;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_rdma_split.sv
// Directed bench for nv_nvdla_sdp_rdma_split: RATIO=2 instance for most
// scenarios plus a RATIO=8 instance for the 16-beat 8-bit case.
module tb_nv_nvdla_sdp_rdma_split;

  logic clk;
  logic rst;

  logic         cfg_dp_8;
  logic         inp_pvld;
  logic         inp_prdy;
  logic [511:0] inp_data;
  logic         out_pvld;
  logic         out_prdy;
  logic [255:0] out_data;

  logic          b_cfg_dp_8;
  logic          b_inp_pvld;
  logic          b_inp_prdy;
  logic [2047:0] b_inp_data;
  logic          b_out_pvld;
  logic          b_out_prdy;
  logic [255:0]  b_out_data;

`ifdef NVDLA_SDP_SPLIT_LAST_EN
  logic out_last;
  logic b_out_last;
`endif

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nv_nvdla_sdp_rdma_split #(.IW(256), .OW(512)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_dp_8       (cfg_dp_8),
    .inp_pvld       (inp_pvld),
    .inp_prdy       (inp_prdy),
    .inp_data       (inp_data),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data)
`ifdef NVDLA_SDP_SPLIT_LAST_EN
    ,
    .out_last       (out_last)
`endif
  );

  nv_nvdla_sdp_rdma_split #(.IW(256), .OW(2048)) dut8 (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_dp_8       (b_cfg_dp_8),
    .inp_pvld       (b_inp_pvld),
    .inp_prdy       (b_inp_prdy),
    .inp_data       (b_inp_data),
    .out_pvld       (b_out_pvld),
    .out_prdy       (b_out_prdy),
    .out_data       (b_out_data)
`ifdef NVDLA_SDP_SPLIT_LAST_EN
    ,
    .out_last       (b_out_last)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_dp_8 = 1'b0; inp_pvld = 1'b0; inp_data = '0; out_prdy = 1'b0;
    b_cfg_dp_8 = 1'b0; b_inp_pvld = 1'b0; b_inp_data = '0; b_out_prdy = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_pvld got=%b exp=0", out_pvld); end
    total++; if (inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL reset_inp_prdy got=%b exp=1", inp_prdy); end
    total++; if (b_out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_out_pvld got=%b exp=0", b_out_pvld); end
    total++; if (b_inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL reset_b_inp_prdy got=%b exp=1", b_inp_prdy); end
`ifdef NVDLA_SDP_SPLIT_LAST_EN
    total++; if (out_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_last got=%b exp=0", out_last); end
`endif
  endtask

  task automatic test_16bit_word();
    logic [255:0] a, b;
    a = {32{8'hAA}};
    b = {32{8'hBB}};
    cfg_dp_8 = 1'b0; out_prdy = 1'b1; inp_pvld = 1'b1; inp_data = {b, a};
    #1;
    total++; if (inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL w16_accept_prdy got=%b exp=1", inp_prdy); end
    step();
    inp_pvld = 1'b0;
    #1;
    total++; if (out_pvld !== 1'b1) begin bad++; $display("[TB] FAIL w16_beat0_pvld got=%b exp=1", out_pvld); end
    total++; if (out_data !== a) begin bad++; $display("[TB] FAIL w16_beat0_data got=%h exp=%h", out_data, a); end
    total++; if (inp_prdy !== 1'b0) begin bad++; $display("[TB] FAIL w16_beat0_prdy got=%b exp=0", inp_prdy); end
`ifdef NVDLA_SDP_SPLIT_LAST_EN
    total++; if (out_last !== 1'b0) begin bad++; $display("[TB] FAIL w16_beat0_last got=%b exp=0", out_last); end
`endif
    step();
    total++; if (out_pvld !== 1'b1) begin bad++; $display("[TB] FAIL w16_beat1_pvld got=%b exp=1", out_pvld); end
    total++; if (out_data !== b) begin bad++; $display("[TB] FAIL w16_beat1_data got=%h exp=%h", out_data, b); end
    total++; if (inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL w16_beat1_prdy got=%b exp=1", inp_prdy); end
`ifdef NVDLA_SDP_SPLIT_LAST_EN
    total++; if (out_last !== 1'b1) begin bad++; $display("[TB] FAIL w16_beat1_last got=%b exp=1", out_last); end
`endif
    step();
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL w16_drained_pvld got=%b exp=0", out_pvld); end
  endtask

  task automatic test_8bit_word();
    logic [511:0] w;
    logic [255:0] exp_beat;
    for (int i = 0; i < 64; i++) w[i*8 +: 8] = 8'(i);
    cfg_dp_8 = 1'b1; out_prdy = 1'b1; inp_pvld = 1'b1; inp_data = w;
    step();
    inp_pvld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cfg_dp_8 = k[0];
      #1;
      exp_beat = '0;
      for (int j = 0; j < 16; j++) exp_beat[j*8 +: 8] = 8'(16 * k + j);
      total++; if (out_pvld !== 1'b1) begin bad++; $display("[TB] FAIL w8_beat%0d_pvld got=%b exp=1", k, out_pvld); end
      total++; if (out_data !== exp_beat) begin bad++; $display("[TB] FAIL w8_beat%0d_data got=%h exp=%h", k, out_data, exp_beat); end
      total++; if (inp_prdy !== (k == 3)) begin bad++; $display("[TB] FAIL w8_beat%0d_prdy got=%b exp=%b", k, inp_prdy, (k == 3)); end
      step();
    end
    cfg_dp_8 = 1'b0;
    #1;
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL w8_drained_pvld got=%b exp=0", out_pvld); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] words [3];
    logic [255:0] exp_beat;
    int nxt;
    for (int n = 0; n < 3; n++) words[n] = {{32{8'(8'h20 + n)}}, {32{8'(8'h10 + n)}}};
    cfg_dp_8 = 1'b0; out_prdy = 1'b1; inp_pvld = 1'b1; inp_data = words[0];
    #1;
    total++; if (inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first_prdy got=%b exp=1", inp_prdy); end
    step();
    nxt = 1;
    for (int c = 1; c <= 6; c++) begin
      inp_pvld = (nxt < 3);
      inp_data = (nxt < 3) ? words[nxt] : '0;
      #1;
      exp_beat = ((c - 1) % 2 == 0) ? {32{8'(8'h10 + (c - 1) / 2)}} : {32{8'(8'h20 + (c - 1) / 2)}};
      total++; if (out_pvld !== 1'b1) begin bad++; $display("[TB] FAIL b2b_c%0d_pvld got=%b exp=1", c, out_pvld); end
      total++; if (out_data !== exp_beat) begin bad++; $display("[TB] FAIL b2b_c%0d_data got=%h exp=%h", c, out_data, exp_beat); end
      total++; if (inp_prdy !== ((c - 1) % 2 == 1)) begin bad++; $display("[TB] FAIL b2b_c%0d_prdy got=%b exp=%b", c, inp_prdy, ((c - 1) % 2 == 1)); end
      if (((c - 1) % 2 == 1) && nxt < 3) nxt++;
      step();
    end
    inp_pvld = 1'b0;
    #1;
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drained_pvld got=%b exp=0", out_pvld); end
  endtask

  task automatic test_backpressure();
    logic [255:0] xl, xh, yl, yh;
    xl = {32{8'h5A}}; xh = {32{8'hC3}};
    yl = {32{8'h11}}; yh = {32{8'h77}};
    cfg_dp_8 = 1'b0; out_prdy = 1'b1; inp_pvld = 1'b1; inp_data = {xh, xl};
    step();
    inp_data = {yh, yl};
    out_prdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (out_pvld !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold%0d_pvld got=%b exp=1", i, out_pvld); end
      total++; if (out_data !== xl) begin bad++; $display("[TB] FAIL bp_hold%0d_data got=%h exp=%h", i, out_data, xl); end
      total++; if (inp_prdy !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold%0d_prdy got=%b exp=0", i, inp_prdy); end
      step();
    end
    out_prdy = 1'b1;
    #1;
    total++; if (out_data !== xl) begin bad++; $display("[TB] FAIL bp_rel_beat0 got=%h exp=%h", out_data, xl); end
    step();
    total++; if (out_data !== xh) begin bad++; $display("[TB] FAIL bp_rel_beat1 got=%h exp=%h", out_data, xh); end
    total++; if (inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL bp_rel_prdy got=%b exp=1", inp_prdy); end
    step();
    inp_pvld = 1'b0;
    #1;
    total++; if (out_data !== yl) begin bad++; $display("[TB] FAIL bp_next_beat0 got=%h exp=%h", out_data, yl); end
    step();
    total++; if (out_data !== yh) begin bad++; $display("[TB] FAIL bp_next_beat1 got=%h exp=%h", out_data, yh); end
    step();
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained_pvld got=%b exp=0", out_pvld); end
  endtask

  task automatic test_reset_mid_word();
    logic [511:0] z, q;
    logic [255:0] exp_beat;
    for (int i = 0; i < 64; i++) z[i*8 +: 8] = 8'(8'h80 + i);
    for (int i = 0; i < 64; i++) q[i*8 +: 8] = 8'(8'hC0 - i);
    cfg_dp_8 = 1'b1; out_prdy = 1'b1; inp_pvld = 1'b1; inp_data = z;
    step();
    inp_pvld = 1'b0;
    step();
    exp_beat = '0;
    for (int j = 0; j < 16; j++) exp_beat[j*8 +: 8] = 8'(8'h90 + j);
    total++; if (out_data !== exp_beat) begin bad++; $display("[TB] FAIL rst_mid_beat1 got=%h exp=%h", out_data, exp_beat); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_pvld got=%b exp=0", out_pvld); end
    total++; if (inp_prdy !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_prdy got=%b exp=1", inp_prdy); end
    cfg_dp_8 = 1'b1; inp_pvld = 1'b1; inp_data = q;
    step();
    inp_pvld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_beat = '0;
      for (int j = 0; j < 16; j++) exp_beat[j*8 +: 8] = 8'(8'hC0 - (16 * k + j));
      total++; if (out_data !== exp_beat) begin bad++; $display("[TB] FAIL rst_new_beat%0d got=%h exp=%h", k, out_data, exp_beat); end
      step();
    end
    #1;
    total++; if (out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL rst_new_drained got=%b exp=0", out_pvld); end
  endtask

  task automatic test_ratio8_dp8();
    logic [2047:0] w1, w2;
    logic [255:0]  exp_beat;
    for (int i = 0; i < 256; i++) w1[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 256; i++) w2[i*8 +: 8] = 8'(255 - i);
    b_cfg_dp_8 = 1'b1; b_out_prdy = 1'b1; b_inp_pvld = 1'b1; b_inp_data = w1;
    step();
    b_inp_data = w2;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_beat = '0;
      for (int j = 0; j < 16; j++) exp_beat[j*8 +: 8] = 8'(16 * k + j);
      total++; if (b_out_data !== exp_beat) begin bad++; $display("[TB] FAIL r8_w1_beat%0d got=%h exp=%h", k, b_out_data, exp_beat); end
      total++; if (b_inp_prdy !== (k == 15)) begin bad++; $display("[TB] FAIL r8_w1_prdy%0d got=%b exp=%b", k, b_inp_prdy, (k == 15)); end
`ifdef NVDLA_SDP_SPLIT_LAST_EN
      total++; if (b_out_last !== (k == 15)) begin bad++; $display("[TB] FAIL r8_w1_last%0d got=%b exp=%b", k, b_out_last, (k == 15)); end
`endif
      step();
    end
    b_inp_pvld = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      exp_beat = '0;
      for (int j = 0; j < 16; j++) exp_beat[j*8 +: 8] = 8'(255 - (16 * k + j));
      total++; if (b_out_pvld !== 1'b1) begin bad++; $display("[TB] FAIL r8_w2_pvld%0d got=%b exp=1", k, b_out_pvld); end
      total++; if (b_out_data !== exp_beat) begin bad++; $display("[TB] FAIL r8_w2_beat%0d got=%h exp=%h", k, b_out_data, exp_beat); end
      step();
    end
    #1;
    total++; if (b_out_pvld !== 1'b0) begin bad++; $display("[TB] FAIL r8_drained_pvld got=%b exp=0", b_out_pvld); end
  endtask

  initial begin
    test_reset();
    test_16bit_word();
    test_8bit_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_ratio8_dp8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
